narrow_clip_64: RTL and testbench

Streaming element-narrowing unit for the vector execute path: converts a run of 64-bit source elements back down to 32-bit results, the inverse of the 32→64 / simm5→64 widening done at operand fetch. Each element is shifted right (arithmetic or logical), then either clipped to the 32-bit range (vnclip/vnclipu) or truncated (vnsra/vnsrl). Sits between the 64-bit ALU result stream and the 32-bit element writeback, with valid/ready on both sides and a start/done handshake per instruction.

---
 rtl/narrow_clip_64_if.sv | 19 +
 rtl/narrow_clip_64.sv | 155 +++++++++++++++
 tb/tb_narrow_clip_64.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/narrow_clip_64_if.sv
// rtl/narrow_clip_64_if.sv - source/result stream bundle for narrow_clip_64
interface narrow_clip_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/narrow_clip_64.sv
// rtl/narrow_clip_64.sv - 64->32 element narrowing (shift, then clip or truncate)
// NARROW_CLIP_EN selects vnclip/vnclipu saturation; undefined gives vnsra/vnsrl truncation.
module narrow_clip_64 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] vl,
    input  logic             is_signed,
    input  logic [5:0]       shamt,
    narrow_clip_64_if.slave  bus,
    output logic             busy,
    output logic             done,
    output logic             vxsat
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic             lat_signed;
    logic [5:0]       lat_shamt;
    logic [31:0]      out_data_r;
    logic             out_valid_r;
    logic [31:0]      narrowed;
    logic             start_acc, in_hs, out_hs;

    assign start_acc     = (state == IDLE) && start;
    assign in_hs         = bus.in_valid && bus.in_ready;
    assign out_hs        = out_valid_r && bus.out_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

`ifdef NARROW_CLIP_EN
    logic signed [63:0] shifted_s;
    logic        [63:0] shifted_u;
    logic               sat;
    logic               vxsat_r;

    assign shifted_s = $signed(bus.in_data) >>> lat_shamt;
    assign shifted_u = bus.in_data >> lat_shamt;

    // Signed result fits iff bits 63..31 are all copies of the sign.
    always_comb begin
        narrowed = 32'h0;
        sat      = 1'b0;
        if (lat_signed) begin
            if (shifted_s[63:31] == {33{shifted_s[63]}}) begin
                narrowed = shifted_s[31:0];
            end else begin
                sat      = 1'b1;
                narrowed = shifted_s[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            if (shifted_u[63:32] == 32'h0) begin
                narrowed = shifted_u[31:0];
            end else begin
                sat      = 1'b1;
                narrowed = 32'hFFFF_FFFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vxsat_r <= 1'b0;
        end else if (start_acc) begin
            vxsat_r <= 1'b0;
        end else if (in_hs && sat) begin
            vxsat_r <= 1'b1;
        end
    end

    assign vxsat = vxsat_r;
`else
    always_comb begin
        narrowed = 32'h0;
        if (lat_signed) begin
            narrowed = 32'($signed(bus.in_data) >>> lat_shamt);
        end else begin
            narrowed = 32'(bus.in_data >> lat_shamt);
        end
    end

    assign vxsat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (vl == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                bus.in_ready = (in_cnt != '0) && (!out_valid_r || bus.out_ready);
                if (out_hs && (out_cnt == ONE)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A same-cycle input refill keeps out_valid high while the old element leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt      <= '0;
            out_cnt     <= '0;
            lat_signed  <= 1'b0;
            lat_shamt   <= 6'd0;
            out_data_r  <= 32'h0;
            out_valid_r <= 1'b0;
        end else begin
            if (start_acc) begin
                in_cnt     <= vl;
                out_cnt    <= vl;
                lat_signed <= is_signed;
                lat_shamt  <= shamt;
            end
            if (in_hs) begin
                in_cnt     <= in_cnt - ONE;
                out_data_r <= narrowed;
            end
            if (out_hs) begin
                out_cnt <= out_cnt - ONE;
            end
            if (in_hs) begin
                out_valid_r <= 1'b1;
            end else if (out_hs) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_narrow_clip_64.sv
// tb/tb_narrow_clip_64.sv - self-checking bench for narrow_clip_64
module tb_narrow_clip_64;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] vl;
    logic       is_signed;
    logic [5:0] shamt;
    logic       busy, done, vxsat;

    narrow_clip_64_if bus ();

    narrow_clip_64 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vl        (vl),
        .is_signed (is_signed),
        .shamt     (shamt),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .vxsat     (vxsat)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] src_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        bit          sg;
        logic [5:0]  sh;
        logic [63:0] din;
        logic [31:0] exp_on;
        logic [31:0] exp_off;
        bit          sat_on;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: treat the element as a mathematical integer, shift, then range-check.
    function automatic void model(input logic [63:0] x, input bit sg, input int sh,
                                  output logic [31:0] r, output bit sat);
        longint          sx;
        longint unsigned ux;
        sat = 1'b0;
        if (sg) begin
            sx = longint'(x) >>> sh;
            r  = 32'(sx);
`ifdef NARROW_CLIP_EN
            if (sx > 64'sd2147483647) begin
                r = 32'h7FFF_FFFF; sat = 1'b1;
            end else if (sx < -64'sd2147483648) begin
                r = 32'h8000_0000; sat = 1'b1;
            end
`endif
        end else begin
            ux = x >> sh;
            r  = 32'(ux);
`ifdef NARROW_CLIP_EN
            if (ux > 64'd4294967295) begin
                r = 32'hFFFF_FFFF; sat = 1'b1;
            end
`endif
        end
    endfunction

    task automatic fill_random(input int n, input bit sg, input int sh, output bit sat_any);
        logic [63:0] x;
        logic [31:0] r;
        bit          s;
        src_q.delete();
        exp_q.delete();
        sat_any = 1'b0;
        for (int i = 0; i < n; i++) begin
            x = {$urandom, $urandom};
            x = 64'($signed(x) >>> $urandom_range(0, 63));
            model(x, sg, sh, r, s);
            src_q.push_back(x);
            exp_q.push_back(r);
            sat_any |= s;
        end
    endtask

    // bp: 0 = out_ready high, 1 = random, 2 = low for three cycles mid-stream.
    task automatic run_instr(input int n, input bit sg, input logic [5:0] sh, input int bp,
                             input bit poke, input bit exp_sat);
        int          ii = 0, oi = 0, cyc = 0, done_cyc = -1;
        bit          fin = 1'b0, hold = 1'b0;
        logic [31:0] held = 32'h0;
        @(negedge clk);
        start = 1'b1; vl = 8'(n); is_signed = sg; shamt = sh;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 400) begin
            bus.in_valid  = (ii < n) && (bp != 1 || $urandom_range(0, 3) != 0);
            bus.in_data   = (ii < n) ? src_q[ii] : {$urandom, $urandom};
            bus.out_ready = (bp == 1) ? 1'($urandom_range(0, 1)) :
                            (bp == 2) ? !(cyc >= 2 && cyc <= 4) : 1'b1;
            if (poke && cyc == 1) begin
                start = 1'b1; vl = 8'(n + 3); shamt = sh + 6'd1; is_signed = ~sg;
            end else begin
                start = 1'b0;
            end
            #1;
            if (oi == n) begin
                check("done_pulse", {62'd0, done, busy}, 64'd3);
                done_cyc = cyc;
                fin = 1'b1;
            end else begin
                check("done_early", {63'd0, done}, 64'd0);
                if (hold) check("held_data", {31'd0, bus.out_valid, bus.out_data}, {31'd0, 1'b1, held});
                hold = bus.out_valid && !bus.out_ready;
                held = bus.out_data;
                if (hold) check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
                if (bus.out_valid && bus.out_ready) begin
                    check($sformatf("out_data[%0d]", oi), {32'd0, bus.out_data}, {32'd0, exp_q[oi]});
                    oi++;
                end
                if (bus.in_valid && bus.in_ready) ii++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        if (!fin) check("timeout", 64'(oi), 64'(n));
        check("in_count", 64'(ii), 64'(n));
        if (bp == 0) check("latency", 64'(done_cyc), 64'(n + 1));
        check("idle_after", {62'd0, done, busy}, 64'd0);
        check("vxsat", {63'd0, vxsat}, {63'd0, exp_sat});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        bit   sat;
        int   ii, oi, n, sh;
        bit   sg;

        tbl[0]  = '{1'b1, 6'd0,  64'd5,                  32'h0000_0005, 32'h0000_0005, 1'b0};
        tbl[1]  = '{1'b1, 6'd0,  64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b0};
        tbl[2]  = '{1'b1, 6'd0,  64'h0000_0000_7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        tbl[3]  = '{1'b1, 6'd4,  64'h0000_0010_0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[4]  = '{1'b0, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{1'b1, 6'd0,  64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};
        tbl[6]  = '{1'b1, 6'd0,  64'hFFFF_FFFF_7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[7]  = '{1'b1, 6'd63, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[8]  = '{1'b0, 6'd63, 64'h8000_0000_0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
        tbl[9]  = '{1'b0, 6'd32, 64'hFFFF_FFFF_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[10] = '{1'b1, 6'd1,  64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        tbl[11] = '{1'b0, 6'd1,  64'h0000_0001_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; vl = 8'd0; is_signed = 1'b0; shamt = 6'd0;
        bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {bus.in_ready, bus.out_valid, busy, done, vxsat, bus.out_data},
              {5'd0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;

        // Basic three-element run, no backpressure.
        src_q = '{64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_7FFF_FFFF};
        exp_q = '{32'h0000_0005, 32'hFFFF_FFF9, 32'h7FFF_FFFF};
        run_instr(3, 1'b1, 6'd0, 0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            src_q = '{tbl[i].din};
`ifdef NARROW_CLIP_EN
            exp_q = '{tbl[i].exp_on};
            sat   = tbl[i].sat_on;
`else
            exp_q = '{tbl[i].exp_off};
            sat   = 1'b0;
`endif
            run_instr(1, tbl[i].sg, tbl[i].sh, 0, 1'b0, sat);
        end

        // Backpressure: four elements with out_ready low for three cycles.
        fill_random(4, 1'b1, 7, sat);
        run_instr(4, 1'b1, 6'd7, 2, 1'b0, sat);

        // Start during RUN must be ignored.
        fill_random(5, 1'b0, 9, sat);
        run_instr(5, 1'b0, 6'd9, 0, 1'b1, sat);

        // vl = 0: done the next cycle, busy for that one cycle, no output.
        @(negedge clk);
        start = 1'b1; vl = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("vl0_done", {61'd0, done, busy, bus.out_valid}, 64'd6);
        @(negedge clk);
        check("vl0_idle", {61'd0, done, busy, bus.out_valid}, 64'd0);

        // Reset in the middle of a five-element run.
        @(negedge clk);
        start = 1'b1; vl = 8'd5; is_signed = 1'b1; shamt = 6'd4;
        @(negedge clk);
        start = 1'b0;
        ii = 0; oi = 0;
        for (int c = 0; c < 20 && oi < 2; c++) begin
            bus.in_valid = 1'b1; bus.in_data = 64'h0000_0010_0000_0000; bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) oi++;
            if (bus.in_valid && bus.in_ready) ii++;
            @(negedge clk);
        end
        check("pre_reset_outs", 64'(oi), 64'd2);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {bus.in_ready, bus.out_valid, busy, done, vxsat, bus.out_data},
              {5'd0, 32'd0});
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        src_q = '{64'd3};
        exp_q = '{32'd3};
        run_instr(1, 1'b1, 6'd0, 0, 1'b0, 1'b0);

        // Randomized instructions against the reference model.
        for (int k = 0; k < 25; k++) begin
            n  = $urandom_range(1, 20);
            sg = 1'($urandom_range(0, 1));
            sh = $urandom_range(0, 63);
            fill_random(n, sg, sh, sat);
            run_instr(n, sg, 6'(sh), (k % 3 == 0) ? 0 : 1, 1'b0, sat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
